debug_spi_transmitter: RTL and testbench
========================================

DEBUG_SPI_TRANSMITTER -- requirements
Module: debug_spi_transmitter

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose parameter SCK_HALF, default 4, clk cycles per SCK half-period (legal range 2..255).
REQ-003 SHALL expose parameter CS_SETUP, default 2, clk cycles from nCS falling to the first SCK rising edge.
REQ-004 SHALL expose parameter CS_HOLD, default 32, idle clk cycles nCS stays low after a word while waiting for the next request.
REQ-005 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: push_data  input  16  word to transmit; valid in the cycle push_request is high.
REQ-008 Port: push_request  input  1  one-cycle request (IPush/IPushMasterDebug master side).
REQ-009 Port: push_done  output  1  one-cycle pulse when the word has been fully shifted out.
REQ-010 Port: nCS  output  1  SPI chip select, active low.
REQ-011 Port: sck  output  1  SPI clock, idle low.
REQ-012 Port: mosi  output  1  SPI serial data out.
REQ-013 Port: miso  input  1  SPI serial data in.
REQ-014 Port: rx_data  output  16  word captured from miso during the last transfer.
REQ-015 Port: rx_valid  output  1  one-cycle pulse, same cycle as push_done, when rx_data updates.

Function
REQ-016 SPI mode 0: mosi changes while sck is low; miso is sampled on each sck rising edge; MSB first; 16 bits per word.
REQ-017 States: IDLE, SETUP, SHIFT, HOLD.
REQ-018 IDLE: nCS=1, sck=0; push_request=1 latches push_data into the tx shift register, drives bit 15 onto mosi, sets nCS=0 and goes to SETUP.
REQ-019 SETUP: stays CS_SETUP cycles, then goes to SHIFT.
REQ-020 SHIFT: sck toggles every SCK_HALF clk cycles; each falling edge presents the next bit; after the 16th falling edge sck=0, push_done=1 and rx_valid=1 for exactly one cycle, then goes to HOLD.
REQ-021 Word time from request to push_done SHALL be 1 + CS_SETUP + 32*SCK_HALF cycles (default 131), independent of data.
REQ-022 HOLD: nCS stays 0; push_request within CS_HOLD cycles latches the new word and goes directly to SHIFT (no SETUP); otherwise, after CS_HOLD cycles, nCS=1 and goes to IDLE.
REQ-023 push_request while in SETUP or SHIFT SHALL be ignored with no state change; the master must wait for push_done.
REQ-024 push_request in the same cycle as push_done SHALL be ignored; HOLD accepts requests from the following cycle.
REQ-025 rx_data SHALL hold its value until the next transfer completes.
REQ-026 mosi SHALL be 0 while nCS=1.

Reset
REQ-027 Reset SHALL force state=IDLE, nCS=1, sck=0, mosi=0, push_done=0, rx_valid=0, rx_data=0 and clear the shift registers and counters.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no push_done, and nCS=1 from the next cycle.

Structure
REQ-029 A shared package SHALL hold the state enum and the default values of SCK_HALF, CS_SETUP and CS_HOLD.
REQ-030 A sub-module spi_sck_gen SHALL generate sck and its one-cycle rise/fall strobes from SCK_HALF when enabled.

Verification
REQ-031 Single push 16'hAB00 -> mosi sampled on 16 sck rises = 1010_1011_0000_0000, one push_done at cycle 131, nCS high 32 cycles later.
REQ-032 Back-to-back pushes AB00, 02A2, EFAB, 0001, 9D4E, 0000 -> nCS low continuously, 96 sck rises, 6 push_done pulses, sampled words match.
REQ-033 miso tied to mosi, push 16'h9D4E -> rx_data=16'h9D4E with rx_valid coincident with push_done.
REQ-034 Second push_request during SHIFT -> ignored: only 16 sck rises and one push_done.
REQ-035 rst during bit 7 of 16'hEFAB -> nCS=1, sck=0 next cycle, no push_done; a following push 16'h0001 transmits correctly.

Source files
------------

// File: rtl/debug_spi_transmitter_pkg.sv
// Purpose: shared FSM encoding and parameter defaults for the debug SPI transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debug_spi_transmitter_pkg;

  localparam int SCK_HALF_DEFAULT = 4;   // clk cycles per sck half-period (2..255)
  localparam int CS_SETUP_DEFAULT = 2;   // clk cycles spent in SETUP after nCS falls (1..255)
  localparam int CS_HOLD_DEFAULT  = 32;  // clk cycles nCS lingers low waiting for a next word (2..255)
  localparam int WORD_BITS        = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    SHIFT = ST_SHIFT,
    HOLD  = ST_HOLD
  } state_e;

endpackage

// File: rtl/debug_spi_transmitter_spi_sck_gen.sv
// Purpose: SPI clock generator; sck toggles every SCK_HALF clk cycles while en is high.
// Latency: first rising edge SCK_HALF cycles after en rises; rise/fall strobe on the toggling edge.
// Backpressure: none; dropping en returns sck low and restarts the half-period count.
// Ports: clk/rst - clock, sync active-high reset; en - run enable;
//        sck - SPI clock (idle low); rise/fall - high in the cycle whose closing clk edge toggles sck.
module spi_sck_gen
  import debug_spi_transmitter_pkg::*;
#(
  parameter int SCK_HALF = SCK_HALF_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);

  logic [7:0] cnt;
  logic       tick;

  // Strobes are combinational so the caller acts on the same edge that toggles sck.
  assign tick = en && (cnt == HALF_LAST);
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/debug_spi_transmitter.sv
// Purpose: 16-bit SPI mode-0 master for debug words, MSB first, with full-duplex miso capture.
// Latency: push_done 1 + CS_SETUP + 32*SCK_HALF cycles after an accepted request from IDLE, 1 + 32*SCK_HALF from HOLD.
// Backpressure: requests are accepted only in IDLE and in HOLD (from the cycle after push_done); others are dropped.
// Ports: clk/rst - clock, sync active-high reset; push_data/push_request - word and one-cycle request;
//        push_done - word fully shifted; nCS/sck/mosi/miso - SPI pins; rx_data/rx_valid - captured word + strobe.
module debug_spi_transmitter
  import debug_spi_transmitter_pkg::*;
#(
  parameter int SCK_HALF = SCK_HALF_DEFAULT,
  parameter int CS_SETUP = CS_SETUP_DEFAULT,
  parameter int CS_HOLD  = CS_HOLD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] push_data,
  input  logic                 push_request,
  output logic                 push_done,
  output logic                 nCS,
  output logic                 sck,
  output logic                 mosi,
  input  logic                 miso,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid
);

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [3:0] LAST_BIT   = 4'(WORD_BITS - 1);

  state_e               state;
  logic [7:0]           cnt;      // SETUP / HOLD dwell counter
  logic [3:0]           bit_cnt;  // falling edges seen in the current word
  logic [WORD_BITS-1:0] tx_sr;
  logic [WORD_BITS-1:0] rx_sr;
  logic                 sck_en;
  logic                 sck_rise;
  logic                 sck_fall;

  assign sck_en = (state == SHIFT);

  spi_sck_gen #(
    .SCK_HALF (SCK_HALF)
  ) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .sck  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data   <= '0;
      nCS       <= 1'b1;
      mosi      <= 1'b0;
      push_done <= 1'b0;
      rx_valid  <= 1'b0;
    end else begin
      push_done <= 1'b0;
      rx_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (push_request) begin
            tx_sr   <= push_data;
            mosi    <= push_data[WORD_BITS-1];
            nCS     <= 1'b0;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            rx_sr <= {rx_sr[WORD_BITS-2:0], miso};
          end
          // mosi only moves on the edge that takes sck low, giving mode-0 timing.
          if (sck_fall) begin
            tx_sr   <= {tx_sr[WORD_BITS-2:0], 1'b0};
            mosi    <= tx_sr[WORD_BITS-2];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              // All 16 rises have already landed in rx_sr by this last falling edge.
              push_done <= 1'b1;
              rx_valid  <= 1'b1;
              rx_data   <= rx_sr;
              cnt       <= '0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          // cnt == 0 is the push_done cycle; a request there is deliberately dropped.
          if (push_request && (cnt != 8'd0)) begin
            tx_sr   <= push_data;
            mosi    <= push_data[WORD_BITS-1];
            bit_cnt <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end else if (cnt == HOLD_LAST) begin
            nCS   <= 1'b1;
            mosi  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_spi_transmitter.sv
module tb_debug_spi_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] push_data = 16'h0000;
  logic        push_request = 1'b0;
  logic        push_done;
  logic        nCS;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic [15:0] rx_data;
  logic        rx_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard: expected mosi words and expected rx words, pushed when a request is driven.
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          req_cyc  = 0;
  int          nbits    = 0;
  logic [15:0] bits     = 16'h0000;
  logic        prev_sck = 1'b0;

  assign miso = mosi;  // loopback: every received word must equal the transmitted one

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_spi_transmitter dut (
    .clk          (clk),
    .rst          (rst),
    .push_data    (push_data),
    .push_request (push_request),
    .push_done    (push_done),
    .nCS          (nCS),
    .sck          (sck),
    .mosi         (mosi),
    .miso         (miso),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid)
  );

  task automatic scoreboard_monitor();
    logic [15:0] exp_w;
    forever begin
      @(negedge clk);
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        rise_cnt++;
        checks++;
        if (nCS !== 1'b0) begin
          errors++;
          $display("FAIL ncs_at_sck_rise got %b expected 0 at cycle %0d", nCS, cyc);
        end
        bits = {bits[14:0], mosi};
        nbits++;
        if (nbits == 16) begin
          nbits = 0;
          checks++;
          if (tx_q.size() == 0) begin
            errors++;
            $display("FAIL mosi_word got %h expected no transfer", bits);
          end else begin
            exp_w = tx_q.pop_front();
            if (bits !== exp_w) begin
              errors++;
              $display("FAIL mosi_word got %h expected %h", bits, exp_w);
            end
          end
        end
      end
      if (nCS === 1'b1) begin
        checks++;
        if (mosi !== 1'b0) begin
          errors++;
          $display("FAIL mosi_idle got %b expected 0 at cycle %0d", mosi, cyc);
        end
      end
      checks++;
      if (rx_valid !== push_done) begin
        errors++;
        $display("FAIL rx_valid_align got rx_valid=%b expected %b at cycle %0d", rx_valid, push_done, cyc);
      end
      if (push_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_data got %h expected no push_done", rx_data);
        end else begin
          exp_w = rx_q.pop_front();
          if (rx_data !== exp_w) begin
            errors++;
            $display("FAIL rx_data got %h expected %h", rx_data, exp_w);
          end
        end
      end
      prev_sck = sck;
    end
  endtask

  // Settle just after the falling edge so monitor bookkeeping for this cycle is done.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input bit expect_accept);
    @(posedge clk);
    #1;
    push_data    = d;
    push_request = 1'b1;
    if (expect_accept) begin
      req_cyc = cyc;
      tx_q.push_back(d);
      rx_q.push_back(d);
    end
    @(posedge clk);
    #1;
    push_request = 1'b0;
  endtask

  task automatic wait_done(input int prev_done, input int limit, output int elapsed);
    elapsed = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done_cnt != prev_done) begin
        elapsed = done_cyc - req_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    step();
    checks++; if (nCS !== 1'b1)       begin errors++; $display("FAIL reset_ncs got %b expected 1", nCS); end
    checks++; if (sck !== 1'b0)       begin errors++; $display("FAIL reset_sck got %b expected 0", sck); end
    checks++; if (mosi !== 1'b0)      begin errors++; $display("FAIL reset_mosi got %b expected 0", mosi); end
    checks++; if (push_done !== 1'b0) begin errors++; $display("FAIL reset_push_done got %b expected 0", push_done); end
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid got %b expected 0", rx_valid); end
    checks++; if (rx_data !== 16'h0)  begin errors++; $display("FAIL reset_rx_data got %h expected 0000", rx_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_single();
    int r0 = rise_cnt;
    int d0 = done_cnt;
    int el;
    push_word(16'hAB00, 1'b1);
    wait_done(d0, 300, el);
    checks++;
    if (el != 131) begin errors++; $display("FAIL single_word_time got %0d expected 131", el); end
    repeat (31) step();
    checks++;
    if (nCS !== 1'b0) begin errors++; $display("FAIL single_hold_ncs got %b expected 0", nCS); end
    step();
    checks++;
    if (nCS !== 1'b1) begin errors++; $display("FAIL single_release_ncs got %b expected 1", nCS); end
    checks++;
    if (rise_cnt - r0 != 16) begin errors++; $display("FAIL single_rises got %0d expected 16", rise_cnt - r0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_pulses got %0d expected 1", done_cnt - d0); end
    repeat (5) step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [0:5];
    int r0 = rise_cnt;
    int d0 = done_cnt;
    int gaps = 0;
    int el;
    int dprev;
    words = '{16'hAB00, 16'h02A2, 16'hEFAB, 16'h0001, 16'h9D4E, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      dprev = done_cnt;
      push_word(words[i], 1'b1);
      el = -1;
      for (int c = 0; c < 300; c++) begin
        step();
        if (nCS !== 1'b0) gaps++;
        if (done_cnt != dprev) begin
          el = done_cyc - req_cyc;
          break;
        end
      end
      checks++;
      if (el != ((i == 0) ? 131 : 129)) begin
        errors++;
        $display("FAIL b2b_word_time word %0d got %0d expected %0d", i, el, (i == 0) ? 131 : 129);
      end
    end
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL b2b_ncs_gap got %0d high cycles expected 0", gaps); end
    checks++;
    if (rise_cnt - r0 != 96) begin errors++; $display("FAIL b2b_rises got %0d expected 96", rise_cnt - r0); end
    checks++;
    if (done_cnt - d0 != 6) begin errors++; $display("FAIL b2b_done_pulses got %0d expected 6", done_cnt - d0); end
    repeat (40) step();
  endtask

  task automatic test_loopback();
    int d0 = done_cnt;
    int el;
    push_word(16'h9D4E, 1'b1);
    wait_done(d0, 300, el);
    checks++;
    if (el != 131) begin errors++; $display("FAIL loop_word_time got %0d expected 131", el); end
    checks++;
    if (rx_data !== 16'h9D4E) begin errors++; $display("FAIL loop_rx_data got %h expected 9d4e", rx_data); end
    repeat (20) step();
    checks++;
    if (rx_data !== 16'h9D4E) begin errors++; $display("FAIL loop_rx_hold got %h expected 9d4e", rx_data); end
    repeat (20) step();
  endtask

  task automatic test_ignore_during_shift();
    int r0 = rise_cnt;
    int d0 = done_cnt;
    int el;
    push_word(16'h02A2, 1'b1);
    repeat (50) step();
    push_word(16'h1234, 1'b0);
    wait_done(d0, 300, el);
    checks++;
    if (el != 131) begin errors++; $display("FAIL ignore_word_time got %0d expected 131", el); end
    repeat (40) step();
    checks++;
    if (rise_cnt - r0 != 16) begin errors++; $display("FAIL ignore_rises got %0d expected 16", rise_cnt - r0); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL ignore_done_pulses got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_request_on_done();
    int r0 = rise_cnt;
    int d0 = done_cnt;
    push_word(16'h5A5A, 1'b1);
    for (int i = 0; i < 300 && cyc < req_cyc + 131; i++) begin
      @(posedge clk);
      #1;
    end
    push_data    = 16'hFFFF;   // lands exactly in the push_done cycle
    push_request = 1'b1;
    @(posedge clk);
    #1;
    push_request = 1'b0;
    for (int i = 0; i < 300 && cyc < req_cyc + 131 + 33; i++) step();
    checks++;
    if (done_cyc - req_cyc != 131) begin errors++; $display("FAIL ondone_word_time got %0d expected 131", done_cyc - req_cyc); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL ondone_done_pulses got %0d expected 1", done_cnt - d0); end
    checks++;
    if (rise_cnt - r0 != 16) begin errors++; $display("FAIL ondone_rises got %0d expected 16", rise_cnt - r0); end
    checks++;
    if (nCS !== 1'b1) begin errors++; $display("FAIL ondone_release_ncs got %b expected 1", nCS); end
    repeat (10) step();
  endtask

  task automatic test_reset_abort();
    int r0 = rise_cnt;
    int d0 = done_cnt;
    int el;
    push_word(16'hEFAB, 1'b1);
    for (int i = 0; i < 300 && (rise_cnt - r0 < 8); i++) step();
    for (int i = 0; i < 20 && sck !== 1'b0; i++) step();  // bit 7 now on mosi
    checks++;
    if (rise_cnt - r0 != 8) begin errors++; $display("FAIL abort_reach_bit7 got %0d rises expected 8", rise_cnt - r0); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (nCS !== 1'b1) begin errors++; $display("FAIL abort_ncs got %b expected 1", nCS); end
    checks++;
    if (sck !== 1'b0) begin errors++; $display("FAIL abort_sck got %b expected 0", sck); end
    checks++;
    if (rx_data !== 16'h0) begin errors++; $display("FAIL abort_rx_data got %h expected 0000", rx_data); end
    tx_q.delete();
    rx_q.delete();
    nbits = 0;
    repeat (150) step();
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got %0d pulses expected 0", done_cnt - d0); end
    d0 = done_cnt;
    r0 = rise_cnt;
    push_word(16'h0001, 1'b1);
    wait_done(d0, 300, el);
    checks++;
    if (el != 131) begin errors++; $display("FAIL abort_next_word_time got %0d expected 131", el); end
    checks++;
    if (rise_cnt - r0 != 16) begin errors++; $display("FAIL abort_next_rises got %0d expected 16", rise_cnt - r0); end
    repeat (40) step();
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_loopback();
    test_ignore_during_shift();
    test_request_on_done();
    test_reset_abort();
    checks++;
    if (tx_q.size() != 0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending expected 0/0", tx_q.size(), rx_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
